mem_arbiter: RTL and testbench

//  Shares one 256-bit line-wide main-memory port between the I-cache (read-only line fills)
//  and the D-cache (line fills and write-backs). Sits between the two caches and the memory

---
 rtl/mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_arbiter.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one 256-bit line-wide memory port between I-cache fills and D-cache fills/write-backs.
// One transaction at a time, registered one-cycle completion pulse, watchdog for a hung memory.
module mem_arbiter #(
  parameter int          RR_EN   = 0,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  i_addr,
  input  logic         i_read,
  output logic [255:0] i_rdata,
  output logic         i_resp,
  input  logic [31:0]  d_addr,
  input  logic         d_read,
  input  logic         d_write,
  input  logic [255:0] d_wdata,
  output logic [255:0] d_rdata,
  output logic         d_resp,
  output logic [31:0]  mem_addr,
  output logic         mem_read,
  output logic         mem_write,
  output logic [255:0] mem_wdata,
  input  logic [255:0] mem_rdata,
  input  logic         mem_resp,
  output logic         timeout_err
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

  localparam logic [31:0] WD_LAST   = (TIMEOUT == 0) ? 32'd0 : TIMEOUT - 1;
  localparam logic [31:0] LINE_MASK = 32'hFFFF_FFE0;

  state_t      state, state_nx;
  logic        last_d;
  logic [31:0] wdog;
  logic        d_req, grant_d, grant_i, busy, abort, finish;

  always_comb begin
    d_req    = d_read | d_write;
    grant_d  = d_req && (!i_read || (RR_EN == 0) || !last_d);
    grant_i  = i_read && !grant_d;
    busy     = (state == BUSY_I) || (state == BUSY_D);
    // mem_resp in the final watchdog cycle takes precedence over the abort
    abort    = busy && !mem_resp && (TIMEOUT != 0) && (wdog == WD_LAST);
    finish   = (busy && mem_resp) || abort;
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (grant_d)      state_nx = BUSY_D;
        else if (grant_i) state_nx = BUSY_I;
      end
      BUSY_I, BUSY_D: begin
        if (finish) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_addr    <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_wdata   <= '0;
      i_rdata     <= '0;
      d_rdata     <= '0;
      i_resp      <= 1'b0;
      d_resp      <= 1'b0;
      timeout_err <= 1'b0;
      last_d      <= 1'b0;
      wdog        <= '0;
    end else begin
      i_resp <= 1'b0;
      d_resp <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_d) begin
            // a simultaneous read+write is a protocol error and is served as a write
            mem_addr  <= d_addr & LINE_MASK;
            mem_write <= d_write;
            mem_read  <= d_read & ~d_write;
            mem_wdata <= d_wdata;
            wdog      <= '0;
          end else if (grant_i) begin
            mem_addr  <= i_addr & LINE_MASK;
            mem_write <= 1'b0;
            mem_read  <= 1'b1;
            mem_wdata <= '0;
            wdog      <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          if (finish) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (abort) timeout_err <= 1'b1;
            if (state == BUSY_D) begin
              d_resp <= 1'b1;
              if (abort)         d_rdata <= '0;
              else if (mem_read) d_rdata <= mem_rdata;
            end else begin
              i_resp <= 1'b1;
              if (abort)         i_rdata <= '0;
              else if (mem_read) i_rdata <= mem_rdata;
            end
          end else if (TIMEOUT != 0) begin
            wdog <= wdog + 32'd1;
          end
        end
        DONE: last_d <= d_resp;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a fixed-priority instance (TIMEOUT=8) and a round-robin one.
// Stimulus pushes expected memory commands and responses; a negedge monitor pops and compares.
module tb_mem_arbiter;

  typedef struct {
    int           inst;
    bit           is_d;
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
    int           lat;    // negative: expect watchdog abort after -lat strobe cycles
  } cmd_t;

  typedef struct {
    int           inst;
    bit           is_d;
    logic [255:0] rdata;
    bit           terr;
    int           cyc;
  } rsp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  i_addr [2];
  logic         i_read [2];
  logic [255:0] i_rdata [2];
  logic         i_resp [2];
  logic [31:0]  d_addr [2];
  logic         d_read [2];
  logic         d_write [2];
  logic [255:0] d_wdata [2];
  logic [255:0] d_rdata [2];
  logic         d_resp [2];
  logic [31:0]  mem_addr [2];
  logic         mem_read [2];
  logic         mem_write [2];
  logic [255:0] mem_wdata [2];
  logic [255:0] mem_rdata [2];
  logic         mem_resp [2];
  logic         timeout_err [2];

  bit           hang [2];
  bit           spur [2];
  int           lat [2];
  int           wcnt [2];
  int           scnt [2];
  logic [255:0] exp_ird [2];
  logic [255:0] exp_drd [2];
  bit           terr_exp [2];
  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;
  cmd_t         cmd_q [$];
  rsp_t         rsp_q [$];

  mem_arbiter #(.RR_EN(0), .TIMEOUT(8)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .i_addr(i_addr[0]), .i_read(i_read[0]), .i_rdata(i_rdata[0]), .i_resp(i_resp[0]),
    .d_addr(d_addr[0]), .d_read(d_read[0]), .d_write(d_write[0]), .d_wdata(d_wdata[0]),
    .d_rdata(d_rdata[0]), .d_resp(d_resp[0]),
    .mem_addr(mem_addr[0]), .mem_read(mem_read[0]), .mem_write(mem_write[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .mem_resp(mem_resp[0]),
    .timeout_err(timeout_err[0])
  );

  mem_arbiter #(.RR_EN(1), .TIMEOUT(1024)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .i_addr(i_addr[1]), .i_read(i_read[1]), .i_rdata(i_rdata[1]), .i_resp(i_resp[1]),
    .d_addr(d_addr[1]), .d_read(d_read[1]), .d_write(d_write[1]), .d_wdata(d_wdata[1]),
    .d_rdata(d_rdata[1]), .d_resp(d_resp[1]),
    .mem_addr(mem_addr[1]), .mem_read(mem_read[1]), .mem_write(mem_write[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .mem_resp(mem_resp[1]),
    .timeout_err(timeout_err[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [255:0] line_of(input logic [31:0] a);
    logic [255:0] d;
    for (int unsigned w = 0; w < 8; w++) d[w*32 +: 32] = (a ^ 32'hC3A5_0F1E) + 32'h0101_0101 * w;
    return d;
  endfunction

  // memory model: answers after lat[k] strobe cycles, never when hung, spuriously when spur
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) wcnt[k] <= (mem_read[k] | mem_write[k]) ? wcnt[k] + 1 : 0;
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      mem_resp[k]  = spur[k] | ((mem_read[k] | mem_write[k]) & ~hang[k] & (wcnt[k] >= lat[k]));
      mem_rdata[k] = mem_read[k] ? line_of(mem_addr[k]) : '0;
    end
  end

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic bad(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got activity expected none (cycle %0d)", name, cyc);
  endtask

  task automatic mon_mem(input int k);
    cmd_t c;
    if (mem_read[k] | mem_write[k]) begin
      if (cmd_q.size() == 0) begin
        bad("mem_unexpected_strobe");
      end else begin
        c = cmd_q[0];
        scnt[k]++;
        chk("mem_inst", k, c.inst);
        chk("mem_write", mem_write[k], c.wr);
        chk("mem_read", mem_read[k], !c.wr);
        chk("mem_addr", mem_addr[k], c.addr);
        if (c.wr) chk("mem_wdata", mem_wdata[k], c.wdata);
        if (mem_resp[k]) begin
          chk("strobe_cycles", scnt[k], c.lat + 1);
          void'(cmd_q.pop_front());
          scnt[k] = 0;
        end
      end
    end else if (scnt[k] != 0) begin
      if (cmd_q.size() == 0) bad("mem_unexpected_drop");
      else begin
        chk("abort_cycles", scnt[k], -cmd_q[0].lat);
        void'(cmd_q.pop_front());
      end
      scnt[k] = 0;
    end
  endtask

  task automatic mon_rsp(input int k);
    rsp_t r;
    logic [255:0] got;
    if (i_resp[k] | d_resp[k]) begin
      if (rsp_q.size() == 0) begin
        bad("unexpected_resp");
      end else begin
        r   = rsp_q.pop_front();
        got = r.is_d ? d_rdata[k] : i_rdata[k];
        chk("resp_inst", k, r.inst);
        chk("d_resp", d_resp[k], r.is_d);
        chk("i_resp", i_resp[k], !r.is_d);
        chk("resp_rdata", got, r.rdata);
        chk("resp_timeout_err", timeout_err[k], r.terr);
        chk("resp_cycle", cyc, r.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      scnt[0] = 0;
      scnt[1] = 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        mon_mem(k);
        mon_rsp(k);
      end
    end
  end

  task automatic push_cmd(input int k, input bit is_d, input bit wr, input logic [31:0] a,
                          input logic [255:0] wd, input int l);
    cmd_t c;
    c.inst = k; c.is_d = is_d; c.wr = wr; c.addr = a & 32'hFFFF_FFE0; c.wdata = wd; c.lat = l;
    cmd_q.push_back(c);
  endtask

  task automatic push_rsp(input int k, input bit is_d, input logic [255:0] rd, input bit te, input int c);
    rsp_t r;
    r.inst = k; r.is_d = is_d; r.rdata = rd; r.terr = te; r.cyc = c;
    rsp_q.push_back(r);
  endtask

  task automatic exp_i(input int k, input logic [31:0] a, input int l, input int c);
    lat[k] = l;
    exp_ird[k] = line_of(a & 32'hFFFF_FFE0);
    push_cmd(k, 1'b0, 1'b0, a, '0, l);
    push_rsp(k, 1'b0, exp_ird[k], terr_exp[k], c);
  endtask

  task automatic exp_d(input int k, input logic [31:0] a, input bit wr, input logic [255:0] wd,
                       input int l, input int c);
    lat[k] = l;
    if (!wr) exp_drd[k] = line_of(a & 32'hFFFF_FFE0);
    push_cmd(k, 1'b1, wr, a, wd, l);
    push_rsp(k, 1'b1, exp_drd[k], terr_exp[k], c);
  endtask

  task automatic req_i(input int k, input logic [31:0] a);
    bit seen = 1'b0;
    i_addr[k] = a;
    i_read[k] = 1'b1;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      seen = i_resp[k];
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL i_req_wait: got no i_resp expected i_resp within 200 cycles");
    end
    @(posedge clk); #1;
    i_read[k] = 1'b0;
  endtask

  task automatic req_d(input int k, input logic [31:0] a, input bit rd, input bit wr, input logic [255:0] wd);
    bit seen = 1'b0;
    d_addr[k]  = a;
    d_read[k]  = rd;
    d_write[k] = wr;
    d_wdata[k] = wd;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      seen = d_resp[k];
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL d_req_wait: got no d_resp expected d_resp within 200 cycles");
    end
    @(posedge clk); #1;
    d_read[k]  = 1'b0;
    d_write[k] = 1'b0;
  endtask

  task automatic run_i(input int k, input logic [31:0] a, input int l);
    exp_i(k, a, l, cyc + 2 + l);
    req_i(k, a);
  endtask

  task automatic run_d(input int k, input logic [31:0] a, input bit rd, input bit wr,
                       input logic [255:0] wd, input int l);
    exp_d(k, a, wr, wd, l, cyc + 2 + l);
    req_d(k, a, rd, wr, wd);
  endtask

  // simultaneous requests on a zero-latency memory: winner at +2, loser at +5
  task automatic both(input int k, input logic [31:0] ia, input logic [31:0] da, input bit d_first);
    int n0 = cyc;
    if (d_first) begin
      exp_d(k, da, 1'b0, '0, 0, n0 + 2);
      exp_i(k, ia, 0, n0 + 5);
    end else begin
      exp_i(k, ia, 0, n0 + 2);
      exp_d(k, da, 1'b0, '0, 0, n0 + 5);
    end
    fork
      req_i(k, ia);
      req_d(k, da, 1'b1, 1'b0, '0);
    join
  endtask

  task automatic chk_zero(input int k);
    chk("rst_mem_read", mem_read[k], 1'b0);
    chk("rst_mem_write", mem_write[k], 1'b0);
    chk("rst_mem_addr", mem_addr[k], '0);
    chk("rst_mem_wdata", mem_wdata[k], '0);
    chk("rst_i_resp", i_resp[k], 1'b0);
    chk("rst_d_resp", d_resp[k], 1'b0);
    chk("rst_i_rdata", i_rdata[k], '0);
    chk("rst_d_rdata", d_rdata[k], '0);
    chk("rst_timeout_err", timeout_err[k], 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: got no completion expected finish before 200000");
    $fatal(1);
  end

  initial begin
    logic [255:0] wd;
    int n0;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      i_addr[k] = '0; i_read[k] = 1'b0; d_addr[k] = '0; d_read[k] = 1'b0; d_write[k] = 1'b0;
      d_wdata[k] = '0; hang[k] = 1'b0; spur[k] = 1'b0; lat[k] = 0;
      exp_ird[k] = '0; exp_drd[k] = '0; terr_exp[k] = 1'b0;
    end
    i_read[0] = 1'b1;
    i_addr[0] = 32'h0000_1234;

    // reset held with a pending I request
    @(posedge clk);
    repeat (4) begin
      @(negedge clk);
      chk_zero(0);
      chk_zero(1);
      @(posedge clk);
    end
    #1;
    exp_i(0, 32'h0000_1234, 0, cyc + 2);
    rst_n = 1'b1;
    @(negedge clk);
    chk("strobe_in_release_cycle", mem_read[0], 1'b0);
    req_i(0, 32'h0000_1234);

    run_i(0, 32'hFFFF_FFFF, 0);
    run_d(0, 32'h8000_0047, 1'b1, 1'b0, '0, 2);

    // write-back with slow memory; address input moves while busy and must be ignored
    wd = {32{8'hA5}};
    n0 = cyc;
    exp_d(0, 32'h0000_3C1F, 1'b1, wd, 5, n0 + 7);
    fork
      req_d(0, 32'h0000_3C1F, 1'b0, 1'b1, wd);
      begin
        repeat (2) @(posedge clk);
        #1;
        d_addr[0] = 32'h0BAD_F000;
      end
    join

    wd = {8{32'h1357_9BDF}};
    run_d(0, 32'h0000_5000, 1'b1, 1'b1, wd, 1);

    spur[0] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("spur_i_resp", i_resp[0], 1'b0);
      chk("spur_d_resp", d_resp[0], 1'b0);
      chk("spur_mem_read", mem_read[0], 1'b0);
    end
    @(posedge clk); #1;
    spur[0] = 1'b0;

    both(0, 32'h0000_0100, 32'h0000_0200, 1'b1);
    run_i(0, 32'h0000_0300, 0);
    both(0, 32'h0000_0400, 32'h0000_0500, 1'b1);
    run_d(0, 32'h0000_0600, 1'b1, 1'b0, '0, 0);
    both(0, 32'h0000_0700, 32'h0000_0800, 1'b1);

    both(1, 32'h0001_0100, 32'h0001_0200, 1'b1);
    run_d(1, 32'h0001_0300, 1'b1, 1'b0, '0, 0);
    both(1, 32'h0001_0400, 32'h0001_0500, 1'b0);

    // mem_resp arrives on the last watchdog cycle: normal completion
    run_i(0, 32'h0000_9000, 7);

    n0 = cyc;
    hang[0] = 1'b1;
    push_cmd(0, 1'b0, 1'b0, 32'h0000_A000, '0, -8);
    exp_ird[0]  = '0;
    terr_exp[0] = 1'b1;
    push_rsp(0, 1'b0, '0, 1'b1, n0 + 9);
    req_i(0, 32'h0000_A000);
    hang[0] = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("timeout_err_sticky", timeout_err[0], 1'b1);
    end
    @(posedge clk); #1;
    run_i(0, 32'h0000_B000, 0);

    // reset in the middle of a D read
    lat[0] = 5;
    push_cmd(0, 1'b1, 1'b0, 32'h0000_C000, '0, 5);
    d_addr[0] = 32'h0000_C000;
    d_read[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    d_read[0] = 1'b0;
    cmd_q.delete();
    rsp_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("midrst_mem_read", mem_read[0], 1'b0);
    chk("midrst_mem_addr", mem_addr[0], '0);
    chk("midrst_d_resp", d_resp[0], 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("midrst_d_resp2", d_resp[0], 1'b0);
    chk("midrst_timeout_err", timeout_err[0], 1'b0);
    chk("midrst_d_rdata", d_rdata[0], '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      exp_ird[k] = '0; exp_drd[k] = '0; terr_exp[k] = 1'b0;
    end
    run_d(0, 32'h0000_D000, 1'b1, 1'b0, '0, 0);
    run_i(0, 32'h0000_E000, 1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("cmd_queue_drained", cmd_q.size(), 0);
    chk("rsp_queue_drained", rsp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
